// File: rtl/rc4_pkg.sv
// Shared types and defaults for the RC4 decoder core stages.
package rc4_pkg;

  localparam int RC4_N          = 256;
  localparam int DEF_MSG_LEN    = 32;
  localparam int DEF_MSG_ADDR_W = 5;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_I,
    READ_I,
    ADDR_J,
    READ_J,
    WR_I,
    WR_J,
    ADDR_F,
    READ_F,
    WR_D,
    DONE
  } rc4_state_e;

endpackage

// File: rtl/rc4_decrypt_message_comb_logic.sv
// Next-state decode for the RC4 PRGA message decrypt stage.
module rc4_decrypt_message_comb_logic
  import rc4_pkg::*;
(
  input  rc4_state_e state,
  input  logic       start,
  input  logic       last_byte,
  output rc4_state_e next_state
);

  always_comb begin
    next_state = state;
    // Losing start in any busy state abandons the run without further writes.
    if (state != IDLE && state != DONE && !start) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) next_state = ADDR_I;
        ADDR_I:  next_state = READ_I;
        READ_I:  next_state = ADDR_J;
        ADDR_J:  next_state = READ_J;
        READ_J:  next_state = WR_I;
        WR_I:    next_state = WR_J;
        WR_J:    next_state = ADDR_F;
        ADDR_F:  next_state = READ_F;
        READ_F:  next_state = WR_D;
        WR_D:    next_state = last_byte ? DONE : ADDR_I;
        DONE:    if (!start) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rc4_decrypt_message.sv
// RC4 keystream generation (PRGA): swaps S in place and writes enc^keystream into d_ram.
//  state  | meaning
//  IDLE   | waiting for start; i=1, j=0, k=0 loaded on start
//  ADDR_I | present i to S;        READ_I | capture si, j += si
//  ADDR_J | present j to S;        READ_J | capture sj
//  WR_I   | S[i] <= sj;            WR_J   | S[j] <= si
//  ADDR_F | present si+sj / k;     READ_F | capture keystream f and cipher byte e
//  WR_D   | d[k] <= f^e, i += 1;   DONE   | finish held until start drops
module rc4_decrypt_message
  import rc4_pkg::*;
#(
  parameter int MSG_LEN    = DEF_MSG_LEN,
  parameter int MSG_ADDR_W = DEF_MSG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  decrypt_message_start,
  output logic                  decrypt_message_finish,
  output logic [7:0]            s_addr,
  output logic [7:0]            s_wrdata,
  output logic                  s_wren,
  input  logic [7:0]            s_q,
  output logic [MSG_ADDR_W-1:0] enc_addr,
  input  logic [7:0]            enc_q,
  output logic [MSG_ADDR_W-1:0] d_addr,
  output logic [7:0]            d_wrdata,
  output logic                  d_wren
);

  localparam int S_ADDR_W = $clog2(RC4_N);

  rc4_state_e            state, next_state;
  logic [S_ADDR_W-1:0]   i, j;
  logic [7:0]            si, sj, f, e;
  logic [MSG_ADDR_W-1:0] k;
  logic                  last_byte;
  logic [S_ADDR_W-1:0]   f_addr;
  logic                  finish_q;

  assign last_byte = (k == MSG_ADDR_W'(MSG_LEN - 1));
  assign f_addr    = si + sj;

  rc4_decrypt_message_comb_logic u_comb_logic (
    .state      (state),
    .start      (decrypt_message_start),
    .last_byte  (last_byte),
    .next_state (next_state)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      i        <= 8'd1;
      j        <= '0;
      k        <= '0;
      si       <= '0;
      sj       <= '0;
      f        <= '0;
      e        <= '0;
      finish_q <= 1'b0;
    end else begin
      state    <= next_state;
      // Registered off DONE, so finish trails the DONE state by one clock.
      finish_q <= (state == DONE) && decrypt_message_start;
      case (state)
        IDLE: begin
          if (decrypt_message_start) begin
            i <= 8'd1;
            j <= '0;
            k <= '0;
          end
        end
        READ_I: begin
          si <= s_q;
          j  <= j + s_q;
        end
        READ_J: sj <= s_q;
        READ_F: begin
          f <= s_q;
          e <= enc_q;
        end
        WR_D: begin
          i <= i + 8'd1;
          if (!last_byte) k <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    enc_addr = '0;
    d_addr   = '0;
    d_wrdata = '0;
    d_wren   = 1'b0;
    case (state)
      ADDR_I, READ_I: s_addr = i;
      ADDR_J, READ_J: s_addr = j;
      WR_I: begin
        s_addr   = i;
        s_wrdata = sj;
        s_wren   = 1'b1;
      end
      WR_J: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
      end
      ADDR_F, READ_F: begin
        s_addr   = f_addr;
        enc_addr = k;
      end
      WR_D: begin
        d_addr   = k;
        d_wrdata = f ^ e;
        d_wren   = 1'b1;
      end
      default: ;
    endcase
  end

  assign decrypt_message_finish = finish_q;

endmodule
